// File: rtl/elevador_pkg.sv
// Shared state codes, floor encodings and sensor helpers for the
// three-floor elevator call scheduler.
package elevador_pkg;

    localparam int NUM_FLOORS = 3;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        MOVE_UP   = 4'd1,
        MOVE_DOWN = 4'd2,
        DOOR      = 4'd3,
        HALT      = 4'd4,
        FAULT     = 4'd15
    } state_e;

    localparam logic [1:0] FLOOR1 = 2'd1;
    localparam logic [1:0] FLOOR2 = 2'd2;
    localparam logic [1:0] FLOOR3 = 2'd3;

    function automatic logic sensor_onehot(input logic [NUM_FLOORS-1:0] f);
        return (f != 3'b000) && ((f & (f - 3'b001)) == 3'b000);
    endfunction

    function automatic logic [1:0] sensor_floor(input logic [NUM_FLOORS-1:0] f);
        logic [1:0] fl;
        case (f)
            3'b001:  fl = FLOOR1;
            3'b010:  fl = FLOOR2;
            3'b100:  fl = FLOOR3;
            default: fl = 2'd0;
        endcase
        return fl;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [1:0] fl);
        logic [NUM_FLOORS-1:0] m;
        case (fl)
            FLOOR1:  m = 3'b001;
            FLOOR2:  m = 3'b010;
            FLOOR3:  m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Call, sensor and status bundle between the car environment (master)
// and the scheduler (slave).
interface elevator_call_scheduler_if;
    import elevador_pkg::*;

    logic [NUM_FLOORS-1:0] p;
    logic [NUM_FLOORS-1:0] f;
    logic                  s;
    logic                  mup;
    logic                  mdw;
    logic                  door_open;
    logic [1:0]            floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  dir_up;
    logic                  fault;
    logic [3:0]            est;

    modport master (
        output p, f, s,
        input  mup, mdw, door_open, floor, pending, dir_up, fault, est
    );

    modport slave (
        input  p, f, s,
        output mup, mdw, door_open, floor, pending, dir_up, fault, est
    );
endinterface

// File: rtl/elevator_door_timer.sv
// Loadable down-counter timing the door-open phase; done is high once the
// count has run out.
module elevator_door_timer #(
    parameter int DOOR_CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic restart,
    input  logic en,
    output logic done
);
    localparam int CW = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DOOR_CYCLES - 1);

    logic [CW-1:0] cnt_r;

    // Reload on start or restart, otherwise count down to zero while enabled
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (load || restart) begin
            cnt_r <= RELOAD;
        end else if (en && (cnt_r != {CW{1'b0}})) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == {CW{1'b0}});
endmodule

// File: rtl/elevator_call_scheduler.sv
// Collective-service call scheduler for a three-floor car: latches calls, tracks
// the car from the floor sensors and sequences motor, door, halt and fault states.
module elevator_call_scheduler
    import elevador_pkg::*;
#(
    parameter int DOOR_CYCLES  = 20,
    parameter int MOVE_TIMEOUT = 200
) (
    input  logic                     clk,
    input  logic                     reset,
    elevator_call_scheduler_if.slave io
);
    localparam int TW = $clog2(MOVE_TIMEOUT);

    state_e                state_r, state_s;
    logic [1:0]            floor_r;
    logic [NUM_FLOORS-1:0] pending_r, pending_s;
    logic                  dir_up_r, dir_up_s;
    logic                  mup_r, mdw_r, door_open_r, fault_r;
    logic [TW-1:0]         move_cnt_r;
    logic                  door_load_s, door_restart_s, door_done_s, door_en_s;

    logic [NUM_FLOORS-1:0] cur_mask_s, below_s, above_s, arr_mask_s, latch_s, calls_s;
    logic                  sensor_ok_s, sensor_bad_s, arrival_s, moving_s, timeout_s;
    logic                  stop_s, call_here_s, up_calls_s, down_calls_s, fault_cond_s;

    assign sensor_ok_s  = sensor_onehot(io.f);
    assign sensor_bad_s = (io.f != 3'b000) && !sensor_ok_s;
    assign arrival_s    = sensor_ok_s && (sensor_floor(io.f) != floor_r);
    assign arr_mask_s   = sensor_ok_s ? io.f : 3'b000;
    assign cur_mask_s   = floor_mask(floor_r);
    assign below_s      = cur_mask_s - 3'b001;
    assign above_s      = ~(below_s | cur_mask_s);
    assign moving_s     = (state_r == MOVE_UP) || (state_r == MOVE_DOWN);
    assign timeout_s    = (move_cnt_r == TW'(MOVE_TIMEOUT - 1));
    assign fault_cond_s = sensor_bad_s || (moving_s && timeout_s && !arrival_s);

    // A call for the floor the car is parked or loading at is served, never stored
    assign latch_s      = io.p & (((state_r == IDLE) || (state_r == DOOR)) ? ~cur_mask_s : 3'b111);
    assign calls_s      = pending_r | io.p;
    assign call_here_s  = (calls_s & cur_mask_s) != 3'b000;
    assign up_calls_s   = (pending_r & above_s) != 3'b000;
    assign down_calls_s = (pending_r & below_s) != 3'b000;
    assign stop_s       = ((calls_s & arr_mask_s) != 3'b000)
                       || ((state_r == MOVE_UP)   && (arr_mask_s == 3'b100))
                       || ((state_r == MOVE_DOWN) && (arr_mask_s == 3'b001));
    assign door_en_s    = (state_r == DOOR);

    elevator_door_timer #(.DOOR_CYCLES(DOOR_CYCLES)) u_door_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (door_load_s),
        .restart (door_restart_s),
        .en      (door_en_s),
        .done    (door_done_s)
    );

    // Next state, call set and direction; fault outranks stop, stop outranks arrival
    always_comb begin
        state_s        = state_r;
        pending_s      = pending_r;
        dir_up_s       = dir_up_r;
        door_load_s    = 1'b0;
        door_restart_s = 1'b0;
        if (state_r == FAULT) begin
            state_s = FAULT;
        end else if (fault_cond_s) begin
            state_s = FAULT;
        end else if (io.s) begin
            state_s   = HALT;
            pending_s = pending_r | latch_s;
        end else begin
            pending_s = pending_r | latch_s;
            case (state_r)
                IDLE: begin
                    if (call_here_s) begin
                        state_s     = DOOR;
                        door_load_s = 1'b1;
                        pending_s   = (pending_r | latch_s) & ~cur_mask_s;
                    end else if (dir_up_r && up_calls_s) begin
                        state_s = MOVE_UP;
                    end else if (!dir_up_r && down_calls_s) begin
                        state_s = MOVE_DOWN;
                    end else if (up_calls_s) begin
                        state_s  = MOVE_UP;
                        dir_up_s = 1'b1;
                    end else if (down_calls_s) begin
                        state_s  = MOVE_DOWN;
                        dir_up_s = 1'b0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (arrival_s && stop_s) begin
                        state_s     = DOOR;
                        door_load_s = 1'b1;
                        pending_s   = (pending_r | io.p) & ~arr_mask_s;
                    end else begin
                        state_s = state_r;
                    end
                end
                DOOR: begin
                    if ((io.p & cur_mask_s) != 3'b000) begin
                        door_restart_s = 1'b1;
                    end else if (door_done_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DOOR;
                    end
                end
                HALT:    state_s = IDLE;
                default: state_s = FAULT;
            endcase
        end
    end

    // State, call and direction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            pending_r <= 3'b000;
            dir_up_r  <= 1'b1;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            dir_up_r  <= dir_up_s;
        end
    end

    // Position tracking; sensors are ignored once faulted
    always_ff @(posedge clk) begin
        if (reset) begin
            floor_r <= FLOOR1;
        end else if ((state_r != FAULT) && sensor_ok_s) begin
            floor_r <= sensor_floor(io.f);
        end else begin
            floor_r <= floor_r;
        end
    end

    // Watchdog on cycles spent moving since the last new floor sensor
    always_ff @(posedge clk) begin
        if (reset) begin
            move_cnt_r <= {TW{1'b0}};
        end else if (!moving_s || arrival_s) begin
            move_cnt_r <= {TW{1'b0}};
        end else if (!timeout_s) begin
            move_cnt_r <= move_cnt_r + TW'(1);
        end else begin
            move_cnt_r <= move_cnt_r;
        end
    end

    // Motor runs only while a move state persists, so a stop drops it on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            mup_r       <= 1'b0;
            mdw_r       <= 1'b0;
            door_open_r <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            mup_r       <= (state_r == MOVE_UP)   && (state_s == MOVE_UP);
            mdw_r       <= (state_r == MOVE_DOWN) && (state_s == MOVE_DOWN);
            door_open_r <= (state_s == DOOR);
            fault_r     <= (state_s == FAULT);
        end
    end

    assign io.mup       = mup_r;
    assign io.mdw       = mdw_r;
    assign io.door_open = door_open_r;
    assign io.floor     = floor_r;
    assign io.pending   = pending_r;
    assign io.dir_up    = dir_up_r;
    assign io.fault     = fault_r;
    assign io.est       = state_r;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed-vector bench for elevator_call_scheduler with hand-computed
// expectations for travel, door timing, halt, fault and timeout behaviour.
module tb_elevator_call_scheduler;

    logic clk = 1'b0;
    logic reset;
    int   n_vec   = 0;
    int   n_err   = 0;
    int   both_hi = 0;

    elevator_call_scheduler_if bus ();

    elevator_call_scheduler #(.DOOR_CYCLES(20), .MOVE_TIMEOUT(200)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mup && bus.mdw) both_hi++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_est"},     16'(bus.est),       16'd0);
        check_val({tag, "_motor"},   16'({bus.mup, bus.mdw, bus.door_open}), 16'd0);
        check_val({tag, "_floor"},   16'(bus.floor),     16'd1);
        check_val({tag, "_pending"}, 16'(bus.pending),   16'd0);
        check_val({tag, "_dir_up"},  16'(bus.dir_up),    16'd1);
        check_val({tag, "_fault"},   16'(bus.fault),     16'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.p = 3'b000;
        bus.f = 3'b001;
        bus.s = 1'b0;
        step(2);
        check_reset_state("rst");
        reset = 1'b0;

        // Floor 1 call to floor 3, passing floor 2
        bus.p = 3'b100; step(1); bus.p = 3'b000;
        check_val("s1_pending", 16'(bus.pending), 16'h4);
        check_val("s1_est_idle", 16'(bus.est), 16'd0);
        step(1);
        check_val("s1_est_up", 16'(bus.est), 16'd1);
        check_val("s1_mup_entry", 16'(bus.mup), 16'd0);
        step(1);
        check_val("s1_mup_on", 16'(bus.mup), 16'd1);
        bus.f = 3'b000; step(3);
        bus.f = 3'b010; step(1);
        check_val("s1_pass_floor", 16'(bus.floor), 16'd2);
        check_val("s1_pass_mup", 16'(bus.mup), 16'd1);
        bus.f = 3'b000; step(3);
        bus.f = 3'b100; step(1);
        check_val("s1_arr_mup", 16'(bus.mup), 16'd0);
        check_val("s1_arr_door", 16'(bus.door_open), 16'd1);
        check_val("s1_arr_pending", 16'(bus.pending), 16'd0);
        check_val("s1_arr_floor", 16'(bus.floor), 16'd3);
        step(19);
        check_val("s1_door_last", 16'({bus.door_open, bus.est}), 16'h13);
        step(1);
        check_val("s1_door_end", 16'({bus.door_open, bus.est}), 16'h00);

        // Floor 3 down to floor 1, then a door restart at floor 1
        bus.p = 3'b001; step(1); bus.p = 3'b000;
        check_val("s2_pending", 16'(bus.pending), 16'h1);
        step(1);
        check_val("s2_est_down", 16'(bus.est), 16'd2);
        check_val("s2_dir", 16'(bus.dir_up), 16'd0);
        step(1);
        check_val("s2_mdw_on", 16'({bus.mup, bus.mdw}), 16'h1);
        bus.f = 3'b000; step(2);
        bus.f = 3'b010; step(1);
        check_val("s2_pass", 16'({bus.floor, bus.mdw}), 16'h5);
        bus.f = 3'b000; step(2);
        bus.f = 3'b001; step(1);
        check_val("s2_arr", 16'({bus.floor, bus.mdw, bus.door_open}), 16'h5);
        step(5);
        bus.p = 3'b001; step(1); bus.p = 3'b000;
        check_val("s2_restart_pending", 16'(bus.pending), 16'd0);
        step(19);
        check_val("s2_restart_door", 16'({bus.door_open, bus.est}), 16'h13);
        step(1);
        check_val("s2_restart_end", 16'({bus.door_open, bus.est}), 16'h00);

        // Two simultaneous up calls, a down call arriving mid-travel
        bus.p = 3'b110; step(1); bus.p = 3'b000;
        check_val("s3_pending", 16'(bus.pending), 16'h6);
        step(1);
        check_val("s3_est_up", 16'({bus.dir_up, bus.est}), 16'h11);
        step(1);
        check_val("s3_mup_on", 16'(bus.mup), 16'd1);
        bus.f = 3'b000; step(1);
        bus.p = 3'b001; step(1); bus.p = 3'b000;
        check_val("s3_pending_all", 16'(bus.pending), 16'h7);
        step(1);
        bus.f = 3'b010; step(1);
        check_val("s3_stop2", 16'({bus.pending, bus.floor, bus.mup, bus.door_open}), 16'h59);
        step(19);
        check_val("s3_door2", 16'(bus.door_open), 16'd1);
        step(1);
        check_val("s3_idle2", 16'(bus.est), 16'd0);
        step(1);
        check_val("s3_resume_up", 16'({bus.dir_up, bus.est}), 16'h11);
        step(1);
        check_val("s3_mup_again", 16'({bus.mup, bus.mdw}), 16'h2);
        bus.f = 3'b000; step(2);
        bus.f = 3'b100; step(1);
        check_val("s3_stop3", 16'({bus.pending, bus.floor, bus.door_open}), 16'hF);
        step(20);
        check_val("s3_idle3", 16'(bus.est), 16'd0);
        step(1);
        check_val("s3_reverse", 16'({bus.dir_up, bus.est}), 16'h02);
        step(1);
        check_val("s3_mdw_on", 16'({bus.mup, bus.mdw}), 16'h1);

        // Emergency stop mid-move, call latched while halted
        bus.f = 3'b000; step(2);
        bus.s = 1'b1; step(1);
        check_val("s4_halt", 16'({bus.mdw, bus.est}), 16'h04);
        bus.p = 3'b010; step(1); bus.p = 3'b000;
        check_val("s4_halt_latch", 16'({bus.pending, bus.door_open}), 16'h6);
        bus.s = 1'b0; step(1);
        check_val("s4_idle", 16'(bus.est), 16'd0);
        step(1);
        check_val("s4_resume", 16'(bus.est), 16'd2);
        step(1);
        check_val("s4_mdw", 16'(bus.mdw), 16'd1);
        bus.f = 3'b010; step(1);
        check_val("s4_stop2", 16'({bus.pending, bus.door_open}), 16'h3);

        // Sensor fault, then reset out of FAULT
        step(3);
        bus.f = 3'b011; step(1);
        check_val("s5_fault", 16'({bus.fault, bus.est}), 16'h1F);
        check_val("s5_outs", 16'({bus.mup, bus.mdw, bus.door_open}), 16'd0);
        bus.f = 3'b010; bus.p = 3'b100; step(3); bus.p = 3'b000;
        check_val("s5_sticky", 16'({bus.fault, bus.est, bus.pending}), 16'hF9);
        bus.f = 3'b001;
        reset = 1'b1; step(1);
        check_reset_state("s5_rst");
        reset = 1'b0;

        // Move timeout with the sensors frozen
        bus.p = 3'b100; step(1); bus.p = 3'b000;
        step(1);
        check_val("s6_est_up", 16'(bus.est), 16'd1);
        step(199);
        check_val("s6_before", 16'({bus.fault, bus.est}), 16'h01);
        step(1);
        check_val("s6_timeout", 16'({bus.fault, bus.est}), 16'h1F);
        check_val("s6_motor", 16'({bus.mup, bus.mdw}), 16'd0);
        reset = 1'b1; step(1);
        check_reset_state("s6_rst");
        reset = 1'b0;

        check_val("mup_mdw_excl", 16'(both_hi), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
